// File: rtl/capture_ctrl_mc.sv
// Multi-channel capture controller for the oscilloscope sample RAM: ADC/RAM clock
// generation, decimation, circular pre/post-trigger capture and auto-mode timeout.
module capture_ctrl_mc #(
    parameter int ADDR_W  = 9,
    parameter int NUM_CH  = 2,
    parameter int SRC_W   = 1,
    parameter int DEC_W   = 4,
    parameter int AUTO_TO = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] trig,
    input  logic [SRC_W-1:0]  trig_src,
    input  logic              trig_edge,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic [ADDR_W-1:0] trig_pos,
    input  logic [DEC_W-1:0]  decimator,
    input  logic              cap_done_clr,
    output logic              adc_clk,
    output logic              rclk,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] trace_end,
    output logic              cap_done,
    output logic              armed,
    output logic              triggered,
    output logic              trig_forced
);

    localparam int DCW  = 1 << DEC_W;
    localparam int TO_W = $clog2(AUTO_TO + 1);
    localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] M_OFF    = 2'b00;
    localparam logic [1:0] M_NORMAL = 2'b01;
    localparam logic [1:0] M_AUTO   = 2'b10;
    localparam logic [1:0] M_SINGLE = 2'b11;

    logic [2:0]        state;
    logic [DCW-1:0]    dec_cnt;
    logic [DCW-1:0]    dec_last;
    logic [ADDR_W:0]   pre_cnt;
    logic [ADDR_W:0]   pre_need;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W-1:0] post_next;
    logic [TO_W-1:0]   to_cnt;
    logic [TO_W-1:0]   to_next;
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] edge_q;
    logic              active;
    logic              smpl;
    logic              sel_now;
    logic              sel_prev;
    logic              edge_det;
    logic              timeout;
    logic              launch;

    assign active    = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
    assign dec_last  = (DCW'(1) << decimator) - DCW'(1);
    assign smpl      = active && adc_clk && (dec_cnt == dec_last);
    assign we        = smpl;
    assign rclk      = ~adc_clk;
    assign pre_need  = DEPTH_V - {1'b0, trig_pos};
    assign post_next = post_cnt + ADDR_W'(1);
    assign to_next   = to_cnt + TO_W'(1);
    assign timeout   = (mode == M_AUTO) && smpl && (to_next == TO_W'(AUTO_TO));
    assign launch    = !cap_done && ((mode == M_NORMAL) || (mode == M_AUTO) ||
                                     ((mode == M_SINGLE) && start));

    // Out-of-range trig_src leaves both taps low, so it can never produce an edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        sel_now  = 1'b0;
        sel_prev = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(trig_src) == i) begin
                sel_now  = sync2[i];
                sel_prev = edge_q[i];
            end
        end
        edge_det = trig_edge ? (sel_now & ~sel_prev) : (~sel_now & sel_prev);
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments only; later writes win.
        if (rst) begin
            adc_clk     <= 1'b0;
            waddr       <= '0;
            trace_end   <= '0;
            cap_done    <= 1'b0;
            armed       <= 1'b0;
            triggered   <= 1'b0;
            trig_forced <= 1'b0;
            state       <= S_IDLE;
            dec_cnt     <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            to_cnt      <= '0;
            sync1       <= '0;
            sync2       <= '0;
            edge_q      <= '0;
        end else begin
            adc_clk <= ~adc_clk;
            sync1   <= trig;
            sync2   <= sync1;
            edge_q  <= sync2;

            if (active && adc_clk)
                dec_cnt <= smpl ? '0 : dec_cnt + DCW'(1);
            if (smpl)
                waddr <= waddr + ADDR_W'(1);

            case (state)
                S_IDLE: begin
                    if (launch) begin
                        state       <= S_PRE;
                        dec_cnt     <= '0;
                        pre_cnt     <= '0;
                        post_cnt    <= '0;
                        to_cnt      <= '0;
                        triggered   <= 1'b0;
                        trig_forced <= 1'b0;
                    end
                end
                S_PRE, S_ARMED, S_POST: begin
                    if (mode == M_OFF) begin
                        state     <= S_IDLE;
                        armed     <= 1'b0;
                        triggered <= 1'b0;
                    end else if (state == S_PRE) begin
                        if (smpl && (pre_cnt != '1))
                            pre_cnt <= pre_cnt + (ADDR_W + 1)'(1);
                        if (pre_cnt >= pre_need) begin
                            state <= S_ARMED;
                            armed <= 1'b1;
                        end
                    end else if (state == S_ARMED) begin
                        if ((mode == M_AUTO) && smpl)
                            to_cnt <= to_next;
                        // A real edge wins over a coincident timeout.
                        if (edge_det || timeout) begin
                            triggered   <= 1'b1;
                            trig_forced <= !edge_det;
                            if (trig_pos == '0) begin
                                state     <= S_DONE;
                                trace_end <= waddr - ADDR_W'(1);
                                cap_done  <= 1'b1;
                                armed     <= 1'b0;
                            end else begin
                                state <= S_POST;
                            end
                        end
                    end else if (smpl) begin
                        post_cnt <= post_next;
                        if (post_next == trig_pos) begin
                            state     <= S_DONE;
                            trace_end <= waddr;
                            cap_done  <= 1'b1;
                            armed     <= 1'b0;
                        end
                    end
                end
                S_DONE: begin
                    if (cap_done_clr) begin
                        cap_done  <= 1'b0;
                        triggered <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_ctrl_mc.sv
// Directed self-checking bench for capture_ctrl_mc with default parameters
// (DEPTH=512, AUTO_TO=1024); a negedge monitor models the RAM write address.
module tb_capture_ctrl_mc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] trig = 2'b00;
    logic [0:0] trig_src = 1'b0;
    logic       trig_edge = 1'b1;
    logic [1:0] mode = 2'b00;
    logic       start = 1'b0;
    logic [8:0] trig_pos = 9'd0;
    logic [3:0] decimator = 4'd0;
    logic       cap_done_clr = 1'b0;
    logic       adc_clk, rclk, we, cap_done, armed, triggered, trig_forced;
    logic [8:0] waddr, trace_end;

    int checks = 0;
    int errors = 0;

    // Write monitor state
    int         wr_count = 0;
    int         cyc = 0;
    int         last_we_cyc = 0;
    int         we_interval = 0;
    int         mon_bad = 0;
    bit         wrap_seen = 1'b0;
    logic [8:0] model_wa = 9'd0;
    logic [8:0] cyc_base = 9'd0;
    logic [8:0] last_wa = 9'd0;
    logic [8:0] exp_te = 9'd0;

    capture_ctrl_mc dut (
        .clk(clk), .rst(rst), .trig(trig), .trig_src(trig_src),
        .trig_edge(trig_edge), .mode(mode), .start(start), .trig_pos(trig_pos),
        .decimator(decimator), .cap_done_clr(cap_done_clr), .adc_clk(adc_clk),
        .rclk(rclk), .we(we), .waddr(waddr), .trace_end(trace_end),
        .cap_done(cap_done), .armed(armed), .triggered(triggered),
        .trig_forced(trig_forced)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        cyc_base = model_wa;
        if (rst) begin
            model_wa = 9'd0;
        end else if (we) begin
            if (waddr !== model_wa) mon_bad++;
            last_wa = model_wa;
            if (model_wa == 9'd511) wrap_seen = 1'b1;
            model_wa = model_wa + 9'd1;
            wr_count++;
            we_interval = cyc - last_we_cyc;
            last_we_cyc = cyc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return armed === 1'b1;
            1:       return triggered === 1'b1;
            default: return cap_done === 1'b1;
        endcase
    endfunction

    task automatic wait_cond(input int sel, input int budget, input string name);
        int n = 0;
        while (!cond(sel) && n < budget) begin
            step(1);
            n++;
        end
        checks++;
        if (!cond(sel)) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles, required 1", name, budget);
        end
    endtask

    task automatic pulse_clr();
        cap_done_clr = 1'b1;
        step(1);
        cap_done_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        checks++;
        if ({adc_clk, rclk, we, cap_done, armed, triggered, trig_forced} !== 7'b0100000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0100000",
                     {adc_clk, rclk, we, cap_done, armed, triggered, trig_forced});
        end
        checks++;
        if ({waddr, trace_end} !== 18'd0) begin
            errors++;
            $display("FAIL reset_addr: got waddr=%0d trace_end=%0d required 0/0", waddr, trace_end);
        end
        rst = 1'b0;
    endtask

    task automatic test_normal();
        int c0, ct;
        mode = 2'b01; trig_src = 1'b0; trig_edge = 1'b1; trig_pos = 9'd100; decimator = 4'd0;
        c0 = wr_count;
        wait_cond(0, 2000, "normal_armed");
        checks++;
        if (wr_count - c0 != 412) begin
            errors++;
            $display("FAIL normal_pre_writes: got %0d required 412", wr_count - c0);
        end
        trig[0] = 1'b1;
        step(2);
        checks++;
        if (triggered !== 1'b0) begin
            errors++;
            $display("FAIL trig_latency_early: got %b required 0", triggered);
        end
        step(1);
        checks++;
        if (triggered !== 1'b1) begin
            errors++;
            $display("FAIL trig_latency: got %b required 1", triggered);
        end
        ct = wr_count;
        wait_cond(2, 400, "normal_done");
        checks++;
        if (wr_count - ct != 100) begin
            errors++;
            $display("FAIL normal_post_writes: got %0d required 100", wr_count - ct);
        end
        checks++;
        if ({trace_end, armed, trig_forced} !== {last_wa, 2'b00}) begin
            errors++;
            $display("FAIL normal_trace_end: got %0d armed=%b forced=%b required %0d/0/0",
                     trace_end, armed, trig_forced, last_wa);
        end
        exp_te = last_wa;
    endtask

    task automatic test_ignore_and_abort();
        int c;
        trig[0] = 1'b0;
        step(2);
        pulse_clr();
        checks++;
        if ({cap_done, triggered} !== 2'b00) begin
            errors++;
            $display("FAIL clr_flags: got %b required 00", {cap_done, triggered});
        end
        step(10);
        trig[0] = 1'b1;
        wait_cond(0, 2000, "ignore_armed");
        checks++;
        if (triggered !== 1'b0) begin
            errors++;
            $display("FAIL pre_edge_ignored: got triggered=%b required 0", triggered);
        end
        c = wr_count;
        trig[1] = 1'b1;
        step(40);
        checks++;
        if ({triggered, armed} !== 2'b01) begin
            errors++;
            $display("FAIL other_channel: got triggered/armed=%b required 01", {triggered, armed});
        end
        checks++;
        if (wr_count - c != 20) begin
            errors++;
            $display("FAIL armed_writes: got %0d required 20", wr_count - c);
        end
        mode = 2'b00;
        step(1);
        checks++;
        if ({armed, triggered, cap_done, trace_end} !== {3'b000, exp_te}) begin
            errors++;
            $display("FAIL abort_armed: got flags=%b te=%0d required 000 te=%0d",
                     {armed, triggered, cap_done}, trace_end, exp_te);
        end
        c = wr_count;
        step(10);
        checks++;
        if (wr_count != c) begin
            errors++;
            $display("FAIL abort_idle_writes: got %0d required 0", wr_count - c);
        end
    endtask

    task automatic test_auto();
        int c0, c1, c2;
        mode = 2'b10; trig_pos = 9'd50;
        c0 = wr_count;
        wait_cond(0, 2000, "auto_armed");
        checks++;
        if (wr_count - c0 != 462) begin
            errors++;
            $display("FAIL auto_pre_writes: got %0d required 462", wr_count - c0);
        end
        c1 = wr_count;
        wait_cond(1, 2200, "auto_triggered");
        checks++;
        if (wr_count - c1 != 1024 || trig_forced !== 1'b1) begin
            errors++;
            $display("FAIL auto_timeout: got %0d samples forced=%b required 1024/1",
                     wr_count - c1, trig_forced);
        end
        c2 = wr_count;
        wait_cond(2, 200, "auto_done");
        checks++;
        if (wr_count - c2 != 50 || trace_end !== last_wa) begin
            errors++;
            $display("FAIL auto_post: got %0d writes te=%0d required 50 te=%0d",
                     wr_count - c2, trace_end, last_wa);
        end
    endtask

    task automatic test_decimator_pos0();
        int c;
        mode = 2'b01; decimator = 4'd3; trig_pos = 9'd0; trig_edge = 1'b0;
        pulse_clr();
        c = wr_count;
        wait_cond(0, 9000, "dec_armed");
        checks++;
        if (wr_count - c != 512 || we_interval != 16) begin
            errors++;
            $display("FAIL dec_pre: got %0d writes interval=%0d required 512/16",
                     wr_count - c, we_interval);
        end
        trig[0] = 1'b0;
        step(2);
        checks++;
        if (triggered !== 1'b0) begin
            errors++;
            $display("FAIL fall_latency_early: got %b required 0", triggered);
        end
        step(1);
        exp_te = cyc_base - 9'd1;
        checks++;
        if ({triggered, cap_done, armed, trace_end} !== {3'b110, exp_te}) begin
            errors++;
            $display("FAIL pos0_done: got flags=%b te=%0d required 110 te=%0d",
                     {triggered, cap_done, armed}, trace_end, exp_te);
        end
        c = wr_count;
        step(40);
        checks++;
        if (wr_count != c) begin
            errors++;
            $display("FAIL done_no_writes: got %0d required 0", wr_count - c);
        end
    endtask

    task automatic test_single();
        int c;
        mode = 2'b11; decimator = 4'd0; trig_pos = 9'd20; trig_edge = 1'b1;
        pulse_clr();
        c = wr_count;
        step(2000);
        checks++;
        if (wr_count != c || armed !== 1'b0) begin
            errors++;
            $display("FAIL single_waits: got %0d writes armed=%b required 0/0", wr_count - c, armed);
        end
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_cond(0, 2000, "single_armed");
        checks++;
        if (wr_count - c != 492) begin
            errors++;
            $display("FAIL single_pre_writes: got %0d required 492", wr_count - c);
        end
        trig[0] = 1'b1;
        step(3);
        checks++;
        if (triggered !== 1'b1) begin
            errors++;
            $display("FAIL single_trig: got %b required 1", triggered);
        end
        step(4);
        mode = 2'b00;
        step(1);
        checks++;
        if ({armed, triggered, cap_done, trace_end} !== {3'b000, exp_te}) begin
            errors++;
            $display("FAIL abort_post: got flags=%b te=%0d required 000 te=%0d",
                     {armed, triggered, cap_done}, trace_end, exp_te);
        end
    endtask

    task automatic test_reset_post();
        trig[0] = 1'b0;
        mode = 2'b01;
        wait_cond(0, 2000, "rst_armed");
        trig[0] = 1'b1;
        step(3);
        checks++;
        if (triggered !== 1'b1) begin
            errors++;
            $display("FAIL rst_trig: got %b required 1", triggered);
        end
        step(3);
        rst = 1'b1;
        step(1);
        checks++;
        if ({adc_clk, rclk, we, cap_done, armed, triggered, trig_forced} !== 7'b0100000 ||
            {waddr, trace_end} !== 18'd0) begin
            errors++;
            $display("FAIL rst_in_post: got flags=%b waddr=%0d te=%0d required 0100000/0/0",
                     {adc_clk, rclk, we, cap_done, armed, triggered, trig_forced}, waddr, trace_end);
        end
        rst = 1'b0;
        step(2);
        checks++;
        if (mon_bad != 0 || !wrap_seen) begin
            errors++;
            $display("FAIL waddr_track: got %0d bad writes wrap=%b required 0/1", mon_bad, wrap_seen);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_ignore_and_abort();
        test_auto();
        test_decimator_pos0();
        test_single();
        test_reset_post();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
